// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and types for the instruction stream assembler.
package riscv_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } asm_state_e;

    typedef struct packed {
        logic [6:0]  funct7;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [31:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational packer: decoded RV32I fields plus a format tag into one instruction word.
module instr_field_encoder
    import riscv_pkg::*;
(
    input  logic [2:0]    fmt,
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          illegal
);

    // Unknown formats fall back to a NOP so a bad beat never writes garbage.
    always_comb begin
        word    = NOP_INSTR;
        illegal = 1'b0;
        case (fmt)
            FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                           fields.rd, fields.opcode};
            FMT_I: word = {fields.imm[11:0], fields.rs1, fields.funct3,
                           fields.rd, fields.opcode};
            FMT_S: word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                           fields.imm[4:0], fields.opcode};
            FMT_B: word = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                           fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
            FMT_U: word = {fields.imm[31:12], fields.rd, fields.opcode};
            FMT_J: word = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                           fields.imm[19:12], fields.rd, fields.opcode};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_assembler.sv
// Streams encoded instruction words into instruction memory at auto-incrementing
// byte addresses, one session per start.
module instr_stream_assembler
    import riscv_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_fmt,
    input  logic [6:0]                 in_opcode,
    input  logic [4:0]                 in_rd,
    input  logic [2:0]                 in_funct3,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [6:0]                 in_funct7,
    input  logic [31:0]                in_imm,
    input  logic                       in_last,
    output logic                       imem_we,
    output logic [31:0]                imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       fmt_err
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  LAST_C  = CW'(DEPTH - 1);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);

    asm_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] beats_q, beats_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    instr_fields_t fields;
    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          accept;

    assign fields = '{funct7: in_funct7, rs2: in_rs2, rs1: in_rs1, funct3: in_funct3,
                      rd: in_rd, opcode: in_opcode, imm: in_imm};

    instr_field_encoder u_encoder (
        .fmt     (in_fmt),
        .fields  (fields),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign accept = in_valid && (state_q == ST_RUN);

    // A pending write retires against the old address before a new start
    // reloads it, so a start coinciding with the final write still wins.
    always_comb begin
        state_d = state_q;
        we_d    = accept;
        wdata_d = accept ? enc_word : wdata_q;
        addr_d  = addr_q;
        count_d = count_q;
        beats_d = beats_q;
        err_d   = err_q;

        if (we_q) begin
            addr_d = addr_q + 32'd4;
            if (count_q != DEPTH_C) begin
                count_d = count_q + ONE_C;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    beats_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    beats_d = beats_q + ONE_C;
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end
                    if (in_last || beats_q == LAST_C) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || we_d;
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            beats_q <= beats_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign count      = count_q;
    assign fmt_err    = err_q;

endmodule

// File: tb/tb_instr_stream_assembler.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_instr_stream_assembler;
    import riscv_pkg::*;

    localparam int          DEPTH   = 64;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          DEPTH_S = 4;
    localparam logic [31:0] BASE_S  = 32'hFFFF_FFF8;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk, reset, start, in_valid, in_last;
    logic [2:0]  in_fmt, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_ready, imem_we, busy, done, fmt_err;
    logic [31:0] imem_addr, imem_wdata;
    logic [6:0]  count;

    logic        start_s, in_valid_s, in_ready_s, imem_we_s, busy_s, done_s, fmt_err_s;
    logic [31:0] imem_addr_s, imem_wdata_s;
    logic [2:0]  count_s;

    wr_t         sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mdl_run, mdl_done, mdl_err;
    int          mdl_beats;
    logic [31:0] mdl_addr;

    instr_stream_assembler #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .count(count), .fmt_err(fmt_err)
    );

    instr_stream_assembler #(.DEPTH(DEPTH_S), .BASE_ADDR(BASE_S)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_last(1'b0), .imem_we(imem_we_s), .imem_addr(imem_addr_s),
        .imem_wdata(imem_wdata_s), .busy(busy_s), .done(done_s), .count(count_s),
        .fmt_err(fmt_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding built from field positions with shifts and masks.
    function automatic logic [31:0] model_word(beat_t b);
        logic [31:0] i;
        logic [31:0] base_rd;
        i       = b.imm;
        base_rd = (32'(b.rd) << 7) | 32'(b.opcode);
        case (b.fmt)
            3'd0: return (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                       | (32'(b.f3) << 12) | base_rd;
            3'd1: return ((i & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | base_rd;
            3'd2: return (((i >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                       | (32'(b.f3) << 12) | ((i & 32'h1F) << 7) | 32'(b.opcode);
            3'd3: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25)
                       | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
                       | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'(b.opcode);
            3'd4: return (i & 32'hFFFF_F000) | base_rd;
            3'd5: return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                       | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | base_rd;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic beat_t mk(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7,
                                 logic [31:0] imm, logic [31:0] exp);
        beat_t b;
        b.fmt = fmt; b.opcode = op; b.rd = rd; b.f3 = f3; b.rs1 = rs1; b.rs2 = rs2;
        b.f7 = f7; b.imm = imm; b.exp = exp;
        return b;
    endfunction

    function automatic beat_t rand_beat(bit allow_bad);
        beat_t b;
        if (allow_bad && $urandom_range(7) == 0) b.fmt = 3'(6 + $urandom_range(1));
        else                                     b.fmt = 3'($urandom_range(5));
        b.opcode = 7'($urandom);
        b.rd     = 5'($urandom);
        b.f3     = 3'($urandom);
        b.rs1    = 5'($urandom);
        b.rs2    = 5'($urandom);
        b.f7     = 7'($urandom);
        b.imm    = $urandom;
        b.exp    = model_word(b);
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_write: got write 0x%08h at 0x%08h, expected none",
                         imem_wdata, imem_addr);
            end else begin
                e = sb_q.pop_front();
                checkOutput("imem_addr", imem_addr, e.addr);
                checkOutput("imem_wdata", imem_wdata, e.data);
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from its own session state.
    task automatic applyStimulus(input beat_t b, input bit valid, input bit last, input bit st);
        in_valid = valid; in_last = last; start = st;
        in_fmt = b.fmt; in_opcode = b.opcode; in_rd = b.rd; in_funct3 = b.f3;
        in_rs1 = b.rs1; in_rs2 = b.rs2; in_funct7 = b.f7; in_imm = b.imm;
        @(negedge clk);
        checkOutput("in_ready", 32'(in_ready), 32'(mdl_run));
        @(posedge clk);
        if (mdl_run) begin
            if (valid) begin
                sb_q.push_back('{addr: mdl_addr, data: b.exp});
                mdl_addr += 32'd4;
                mdl_beats++;
                if (b.fmt > 3'd5) mdl_err = 1'b1;
                if (last || mdl_beats == DEPTH) begin
                    mdl_run  = 1'b0;
                    mdl_done = 1'b1;
                end
            end
        end else if (st) begin
            mdl_run = 1'b1; mdl_done = 1'b0; mdl_err = 1'b0;
            mdl_beats = 0; mdl_addr = BASE;
        end
        #1;
    endtask

    task automatic checkSettled(input string tag);
        beat_t idle_b;
        idle_b = rand_beat(1'b0);
        applyStimulus(idle_b, 1'b0, 1'b0, 1'b0);
        applyStimulus(idle_b, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done), 32'(mdl_done));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(mdl_run));
        checkOutput({tag, "_count"}, 32'(count), 32'(mdl_beats));
        checkOutput({tag, "_fmt_err"}, 32'(fmt_err), 32'(mdl_err));
        checkOutput({tag, "_addr"}, imem_addr, mdl_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mdl_run = 1'b0; mdl_done = 1'b0; mdl_err = 1'b0;
        mdl_beats = 0; mdl_addr = BASE;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, "_addr"}, imem_addr, BASE);
        checkOutput({tag, "_wdata"}, imem_wdata, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_fmt_err"}, 32'(fmt_err), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        beat_t dir[6];
        beat_t b;
        int    prev, left, guard, wr_s;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        start_s = 1'b0; in_valid_s = 1'b0;
        b = rand_beat(1'b0);
        in_fmt = b.fmt; in_opcode = b.opcode; in_rd = b.rd; in_funct3 = b.f3;
        in_rs1 = b.rs1; in_rs2 = b.rs2; in_funct7 = b.f7; in_imm = b.imm;
        modelReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;

        $display("[TB] directed six-beat program");
        dir[0] = mk(FMT_R, OP_RTYPE,  5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0,          32'h002081B3);
        dir[1] = mk(FMT_I, OP_ITYPE,  5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF,  32'hFFF00293);
        dir[2] = mk(FMT_S, OP_STORE,  5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8,          32'h0020A423);
        dir[3] = mk(FMT_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8,          32'h00208463);
        dir[4] = mk(FMT_U, OP_LUI,    5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000,  32'h123450B7);
        dir[5] = mk(FMT_J, OP_JAL,    5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8,          32'h0080006F);
        applyStimulus(dir[0], 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(dir[i], 1'b1, i == 5, 1'b0);
        checkSettled("six_beat");

        $display("[TB] illegal format on second beat");
        applyStimulus(dir[0], 1'b0, 1'b0, 1'b1);
        applyStimulus(dir[0], 1'b1, 1'b0, 1'b0);
        b = mk(3'd7, 7'h7F, 5'd9, 3'd7, 5'd9, 5'd9, 7'h7F, 32'hDEAD_BEEF, 32'h0000_0013);
        applyStimulus(b, 1'b1, 1'b0, 1'b0);
        applyStimulus(dir[1], 1'b1, 1'b1, 1'b0);
        checkSettled("illegal_fmt");
        applyStimulus(dir[0], 1'b0, 1'b0, 1'b1);
        checkSettled("restart_clears_err");
        applyStimulus(dir[2], 1'b1, 1'b1, 1'b0);
        checkSettled("restart_end");

        $display("[TB] valid toggling");
        applyStimulus(dir[0], 1'b0, 1'b0, 1'b1);
        b = rand_beat(1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(b, (i % 2) == 0, i == 8, 1'b0);
            if ((i % 2) == 0) b = rand_beat(1'b0);
        end
        checkSettled("toggle");

        $display("[TB] start ignored while running");
        applyStimulus(dir[0], 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(dir[i], 1'b1, i == 5, i == 2 || i == 3);
        checkSettled("start_in_run");

        $display("[TB] full-depth session without last");
        applyStimulus(dir[0], 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(rand_beat(1'b0), 1'b1, 1'b0, 1'b0);
        applyStimulus(rand_beat(1'b0), 1'b1, 1'b0, 1'b0);
        checkSettled("full_depth");

        $display("[TB] reset during pending write");
        applyStimulus(dir[0], 1'b0, 1'b0, 1'b1);
        applyStimulus(dir[4], 1'b1, 1'b0, 1'b0);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        modelReset();
        @(negedge clk);
        checkResetValues("mid_reset");
        @(posedge clk);
        #1;

        $display("[TB] randomized sessions");
        for (int s = 0; s < 25; s++) begin
            applyStimulus(dir[0], 1'b0, 1'b0, 1'b1);
            left  = 1 + $urandom_range(11);
            b     = rand_beat(1'b1);
            guard = 0;
            while (mdl_run && guard < 200) begin
                bit v;
                v    = $urandom_range(3) != 0;
                prev = mdl_beats;
                applyStimulus(b, v, v && left == 1, $urandom_range(9) == 0);
                if (mdl_beats != prev) begin
                    left--;
                    b = rand_beat(1'b1);
                end
                guard++;
            end
            if (mdl_run) begin
                n_checks++;
                $display("[TB] FAIL session_timeout: got session still running, expected done");
            end
            if ($urandom_range(1) == 1) checkSettled("random");
        end
        checkSettled("random_final");

        $display("[TB] small-depth instance saturation and wrap");
        b = rand_beat(1'b0);
        in_fmt = b.fmt; in_opcode = b.opcode; in_rd = b.rd; in_funct3 = b.f3;
        in_rs1 = b.rs1; in_rs2 = b.rs2; in_funct7 = b.f7; in_imm = b.imm;
        start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0; in_valid_s = 1'b1;
        wr_s = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkOutput("small_in_ready", 32'(in_ready_s), (k < DEPTH_S) ? 32'd1 : 32'd0);
            if (imem_we_s === 1'b1) begin
                checkOutput("small_addr", imem_addr_s, BASE_S + 32'(4 * wr_s));
                checkOutput("small_wdata", imem_wdata_s, b.exp);
                wr_s++;
            end
            @(posedge clk);
            #1;
        end
        in_valid_s = 1'b0;
        @(negedge clk);
        checkOutput("small_writes", 32'(wr_s), 32'(DEPTH_S));
        checkOutput("small_count", 32'(count_s), 32'(DEPTH_S));
        checkOutput("small_done", 32'(done_s), 32'd1);
        checkOutput("small_busy", 32'(busy_s), 32'd0);
        checkOutput("small_next_addr", imem_addr_s, BASE_S + 32'(4 * DEPTH_S));
        checkOutput("small_fmt_err", 32'(fmt_err_s), 32'd0);
        @(posedge clk);
        #1;

        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_stream_assembler.md
Name: instr_stream_assembler

Overview:
- Encoder counterpart to the pipeline's instruction field decoder. It accepts decoded RV32I fields (opcode, rd, funct3, rs1, rs2, funct7, immediate) plus a format tag over a valid/ready stream.
- Each beat is packed into a 32-bit instruction word. Words are written sequentially into instruction memory through a single write port with an auto-incrementing byte address.
- Used to load programs into instruction memory for the 2.5-stage pipeline, and by testbenches to generate instructions from fields.

Parameters:
- DEPTH, 64, maximum words written per session.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after start.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a session; sampled only in IDLE or DONE.
- in_valid  in  1  field beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  in  7  opcode field.
- in_rd  in  5  destination register.
- in_funct3  in  3  funct3 field.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct7  in  7  funct7 field.
- in_imm  in  32  sign-extended immediate as a byte offset. U-format supplies the full upper value, e.g. 0x12345000.
- in_last  in  1  marks the final beat of the session.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  32  byte address of the write.
- imem_wdata  out  32  encoded instruction word.
- busy  out  1  high in RUN or while a write is pending.
- done  out  1  high in DONE.
- count  out  $clog2(DEPTH+1)  number of words written this session.
- fmt_err  out  1  sticky illegal-format flag; cleared by start.

Behaviour:
- Reset values: state=IDLE; in_ready, imem_we, busy, done, fmt_err = 0; count=0; imem_addr=BASE_ADDR; imem_wdata=0. Reset mid-session drops any pending write; no write occurs in the cycle after reset.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: start goes to RUN.
  - RUN: start is ignored. Goes to DONE on acceptance of a beat with in_last=1, or on acceptance of the DEPTH-th beat.
  - DONE: start goes to RUN.
  - Entering RUN clears count and fmt_err and loads the next address to BASE_ADDR.
- Handshake: in_ready = (state==RUN). A beat is accepted when in_valid && in_ready. Fields may change only after acceptance. One beat per cycle is sustained.
- Latency: a beat accepted in cycle N produces imem_we=1 in cycle N+1, with imem_wdata set to the encoded word and imem_addr set to the current address. At that write the address increments by 4 and count increments by 1.
- The final accepted beat is still written in the first cycle of DONE. busy stays high through that write. done is asserted from the same cycle.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Fields unused by a format are ignored.
  - imm[0] is ignored for B and J.
- Illegal fmt (6 or 7): the word written is NOP 32'h0000_0013, fmt_err is set, and the write and count proceed normally.
- Address wraps modulo 2^32 with no flag.
- count saturates at DEPTH. A start asserted in the same cycle as a pending final write is honoured: the write completes and the new session's address begins at BASE_ADDR in the following cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - format codes FMT_R..FMT_J;
  - NOP_INSTR = 32'h0000_0013;
  - opcode constants OP_RTYPE 0x33, OP_ITYPE 0x13, OP_STORE 0x23, OP_BRANCH 0x63, OP_LUI 0x37, OP_JAL 0x6F.
- One natural sub-module, instr_field_encoder: purely combinational, taking fields and fmt and producing the word and an illegal flag. Instantiated once before the output register.

Test Plan:
- start, BASE_ADDR=0, then 6 back-to-back beats (last on the 6th) → writes in cycles 1–6:
  - add x3,x1,x2 → 0x002081B3 at 0x00;
  - addi x5,x0,-1 (imm 0xFFFFFFFF) → 0xFFF00293 at 0x04;
  - sw x2,8(x1) → 0x0020A423 at 0x08;
  - beq x1,x2,8 → 0x00208463 at 0x0C;
  - lui x1 with imm 0x12345000 → 0x123450B7 at 0x10;
  - jal x0,8 → 0x0080006F at 0x14.
  - Afterwards done=1 and count=6.
- in_valid toggled 1/0/1 every cycle → writes only follow accepted beats, addresses stay contiguous, there are no gaps in wdata, and count matches the number of accepted beats.
- in_fmt=7 on the second beat → 0x00000013 written at 0x04 and fmt_err=1. The next start clears fmt_err to 0.
- DEPTH=4, 5 beats offered with no in_last → 4 writes, in_ready=0 after the 4th acceptance, done=1, count=4; the 5th beat is never accepted.
- reset asserted the cycle after an accepted beat → no imem_we in the next cycle, and all outputs are at their reset values.
- start asserted in RUN → ignored: address and count continue unchanged.
